alu_4_bit: RTL and testbench



---
 rtl/alu_4_bit.sv | 83 ++++++++
 tb/tb_alu_4_bit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_4_bit.sv
// 4-bit registered ALU: eight operations selected by op, result and
// carry/borrow, zero and signed-overflow flags registered one cycle later.
module alu_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       overflow_flag,
    output logic       out_valid
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    op_e        op_sel;
    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] nxt_result;
    logic       nxt_carry;
    logic       nxt_overflow;

    assign op_sel = op_e'(op);
    assign sum    = {1'b0, a} + {1'b0, b};
    // Bit 4 of the widened difference is set exactly when a < b (borrow).
    assign diff   = {1'b0, a} - {1'b0, b};

    always_comb begin
        nxt_result   = '0;
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        case (op_sel)
            OP_ADD: begin
                nxt_result   = sum[3:0];
                nxt_carry    = sum[4];
                nxt_overflow = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            OP_SUB: begin
                nxt_result   = diff[3:0];
                nxt_carry    = diff[4];
                nxt_overflow = (a[3] != b[3]) && (diff[3] != a[3]);
            end
            OP_AND:   nxt_result = a & b;
            OP_OR:    nxt_result = a | b;
            OP_XOR:   nxt_result = a ^ b;
            OP_PASSA: nxt_result = a;
            OP_PASSB: nxt_result = b;
            OP_CLEAR: nxt_result = '0;
            default:  nxt_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result        <= '0;
            carry_flag    <= 1'b0;
            zero_flag     <= 1'b1;
            overflow_flag <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result        <= nxt_result;
                carry_flag    <= nxt_carry;
                zero_flag     <= (nxt_result == '0);
                overflow_flag <= nxt_overflow;
            end
        end
    end

endmodule

// File: tb/tb_alu_4_bit.sv
// Directed-vector bench for alu_4_bit; outputs are packed as
// {out_valid, overflow, zero, carry, result[3:0]} for comparison.
module tb_alu_4_bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
    logic       carry_flag;
    logic       zero_flag;
    logic       overflow_flag;
    logic       out_valid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    alu_4_bit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .op            (op),
        .result        (result),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic v, input logic o, input logic z,
                                      input logic c, input logic [3:0] r);
        return {v, o, z, c, r};
    endfunction

    function automatic logic [7:0] obs();
        return {out_valid, overflow_flag, zero_flag, carry_flag, result};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got v/o/z/c/r=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, step through the next rising edge, settle 1ns.
    task automatic apply(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                         input logic [2:0] top);
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_;
        op       = top;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        #12;
        check_eq("reset_initial", obs(), mk(0, 0, 1, 0, 4'b0000));
        rst_n = 1'b1;

        // Load a non-reset state, then reset asynchronously mid-cycle.
        apply(1, 4'b0101, 4'b0011, 3'b101);
        check_eq("pre_reset_pass_a", obs(), mk(1, 0, 0, 0, 4'b0101));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", obs(), mk(0, 0, 1, 0, 4'b0000));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        apply(0, 4'b1111, 4'b1111, 3'b000);
        check_eq("idle_after_release", obs(), mk(0, 0, 1, 0, 4'b0000));

        // Operation sweep with a=0101, b=0011.
        apply(1, 4'b0101, 4'b0011, 3'b000);
        check_eq("add_5_3", obs(), mk(1, 1, 0, 0, 4'b1000));
        apply(1, 4'b0101, 4'b0011, 3'b001);
        check_eq("sub_5_3", obs(), mk(1, 0, 0, 0, 4'b0010));
        apply(1, 4'b0101, 4'b0011, 3'b010);
        check_eq("and", obs(), mk(1, 0, 0, 0, 4'b0001));
        apply(1, 4'b0101, 4'b0011, 3'b011);
        check_eq("or", obs(), mk(1, 0, 0, 0, 4'b0111));
        apply(1, 4'b0101, 4'b0011, 3'b100);
        check_eq("xor", obs(), mk(1, 0, 0, 0, 4'b0110));
        apply(1, 4'b0101, 4'b0011, 3'b101);
        check_eq("pass_a", obs(), mk(1, 0, 0, 0, 4'b0101));
        apply(1, 4'b0101, 4'b0011, 3'b110);
        check_eq("pass_b", obs(), mk(1, 0, 0, 0, 4'b0011));
        apply(1, 4'b0101, 4'b0011, 3'b111);
        check_eq("clear", obs(), mk(1, 0, 1, 0, 4'b0000));

        // Carry, borrow and signed overflow corners.
        apply(1, 4'b1111, 4'b0001, 3'b000);
        check_eq("add_carry", obs(), mk(1, 0, 1, 1, 4'b0000));
        apply(1, 4'b0011, 4'b0101, 3'b001);
        check_eq("sub_borrow", obs(), mk(1, 0, 0, 1, 4'b1110));
        apply(1, 4'b1000, 4'b0001, 3'b001);
        check_eq("sub_overflow", obs(), mk(1, 1, 0, 0, 4'b0111));
        apply(1, 4'b0111, 4'b0001, 3'b000);
        check_eq("add_pos_overflow", obs(), mk(1, 1, 0, 0, 4'b1000));
        apply(1, 4'b1000, 4'b1000, 3'b000);
        check_eq("add_neg_overflow", obs(), mk(1, 1, 1, 1, 4'b0000));

        // Hold while idle with changing operands.
        apply(1, 4'b0010, 4'b0011, 3'b000);
        check_eq("hold_add", obs(), mk(1, 0, 0, 0, 4'b0101));
        apply(0, 4'b1111, 4'b0001, 3'b000);
        check_eq("hold_idle1", obs(), mk(0, 0, 0, 0, 4'b0101));
        apply(0, 4'b1000, 4'b0001, 3'b111);
        check_eq("hold_idle2", obs(), mk(0, 0, 0, 0, 4'b0101));

        // Reset coinciding with a valid op: the op is discarded.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'b0001;
        b        = 4'b0001;
        op       = 3'b000;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_during_op", obs(), mk(0, 0, 1, 0, 4'b0000));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        apply(1, 4'b0110, 4'b0011, 3'b001);
        check_eq("first_after_reset", obs(), mk(1, 0, 0, 0, 4'b0011));
        apply(0, 4'b0000, 4'b0000, 3'b000);
        check_eq("valid_drop", obs(), mk(0, 0, 0, 0, 4'b0011));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
